pipeline_mem: RTL
=================

# pipeline_mem

Memory stage of the RV32IM pipeline, directly downstream of the execute stage. It consumes the registered EX results (ALU result, rs2 store data, rs1 value, rd, opcode, bubble flag), performs data-memory loads/stores against an internal word RAM, and executes all RV32M multiply/divide operations. Divide is iterative, so the block raises a pipeline-wide stall. It registers the writeback result, rd and write-enable for the WB stage, and returns the same value to EX as the MEM forwarding operand.

## Interface
- `DMEM_AW`, default 7: word-address width of the internal data RAM (128 words); the byte address uses bits [DMEM_AW+1:0], and upper bits are ignored (wrap).
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `alu_out_i`  in  32  EX ALU result; this is the byte address for loads/stores.
- `wdata_i`  in  32  rs2 value: store data, and operand 2 for M ops.
- `mul_in1_i`  in  32  rs1 value: operand 1 for M ops.
- `rd_i`  in  5  destination register.
- `main_opcode_i`  in  6  decoded opcode.
- `main_stall_i`  in  1  the incoming instruction is a bubble; it must have no side effects.
- `valid_stall_o`  out  1  pipeline hold request to EX, ID and IF (combinational).
- `wb_data_o`  out  32  registered writeback value.
- `rd_o`  out  5  registered rd.
- `we_o`  out  1  registered register-file write enable.
- `reg_forwarding_mem_o`  out  32  equal to `wb_data_o`; feeds the EX MEM-forwarding path.

## Operation

**Opcode map**
- Loads: 100000 LB, 100001 LH, 100010 LW, 100100 LBU, 100101 LHU.
- Stores: 101000 SB, 101001 SH, 101010 SW.
- M ops are 010fff, with fff:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- Any other opcode passes `alu_out_i` through unchanged.

**Write enable**
- `we_o` = 1 for: loads, 00xxxx, 010xxx and 111xxx opcodes.
- `we_o` = 0 for: stores, 110xxx (branches), 001111 (trap), `rd_i`==0, or `main_stall_i`=1.

**Memory**
- RAM is word-wide, with byte write strobes and asynchronous read.
- Stores write on the clock edge at index `alu_out_i[DMEM_AW+1:2]`:
  - SB writes byte lane `alu_out_i[1:0]` with `wdata_i[7:0]`.
  - SH writes half-word lane `alu_out_i[1]` with `wdata_i[15:0]`.
- Misalignment is trapped upstream, so this block takes no action on it.
- Loads extract the addressed byte or half-word and sign- or zero-extend it according to the opcode.
- Stores are suppressed when `main_stall_i`=1 or `valid_stall_o`=1.

**Multiply (single cycle)**
- Compute the 64-bit product; operand signedness follows MUL/MULH (s×s), MULHSU (s×u), MULHU (u×u).
- MUL returns bits [31:0]; all other multiplies return bits [63:32].

**Divide FSM** (states IDLE, DIV, DONE)
- IDLE, div-class op, not bubble:
  - Assert `valid_stall_o`.
  - Latch the absolute-value operands and the result signs.
  - If the divisor is 0 or a signed overflow is detected, load the special result and go directly to DONE.
  - Otherwise clear the 6-bit counter and go to DIV.
- DIV: one restoring shift-subtract step per cycle; `valid_stall_o`=1; after the step with counter==31, go to DONE.
- DONE:
  - `valid_stall_o`=0.
  - Apply sign correction (the quotient is negated if the operand signs differ; the remainder takes the dividend's sign).
  - Register the result into `wb_data_o`.
  - Return to IDLE.
- Divide by zero: quotient = 0xFFFFFFFF (DIV and DIVU); remainder = dividend.
- Overflow (DIV/REM of 0x80000000 by 0xFFFFFFFF): quotient = 0x80000000, remainder = 0.
- EX inputs are held stable while `valid_stall_o`=1. In DONE the FSM must not restart the divide that is still present on its inputs.

**Output registers**
- Output registers update only when `valid_stall_o`=0.
- While stalled they hold their values, with `we_o` forced to 0 in the stall cycles.

## Timing
- Reset values: `wb_data_o`=0, `rd_o`=0, `we_o`=0, FSM=IDLE, counter=0, `valid_stall_o`=0. RAM contents are not reset.
- Non-divide ops: 1-cycle latency; the inputs present at edge N appear on the outputs after edge N.
- Divide, normal case:
  - `valid_stall_o` is high for 33 cycles (1 in IDLE + 32 in DIV).
  - The result appears on the outputs after the DONE edge, 34 edges after arrival.
- Divide by zero or overflow: `valid_stall_o` is high for 1 cycle, and the result appears 2 edges after arrival.
- `reset_i` during DIV: FSM returns to IDLE and `valid_stall_o`=0 in the next cycle; no partial result is written.
- A bubble carrying a divide opcode does not start the FSM.
- A store immediately followed by a load to the same word returns the new data, because the read is asynchronous after the write edge.

## Test plan
- Store and load:
  - SW 0xDEADBEEF to address 0x10; then LB 0x13 → `wb_data_o`=0xFFFFFFDE.
  - LBU 0x13 → 0x000000DE.
  - LHU 0x10 → 0x0000BEEF.
  - `we_o`=1 on each load, `we_o`=0 on the store.
- Multiply with 0xFFFFFFFF × 0x00000002:
  - MUL → 0xFFFFFFFE; MULH → 0xFFFFFFFF; MULHU → 0x00000001; MULHSU → 0xFFFFFFFF.
  - Each completes in 1 cycle with no stall.
- DIV −7 / 2 → quotient 0xFFFFFFFD; REM → 0xFFFFFFFF. `valid_stall_o` is high for exactly 33 cycles and the result is written once.
- DIVU 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5; DIV 0x80000000 / −1 → 0x80000000. Each stalls for 1 cycle.
- Bubble with opcode SW, or with `rd_i`=0 → memory is unchanged and `we_o`=0. A bubble carrying DIV → no stall.
- Assert `reset_i` on cycle 10 of a DIV → the next cycle shows state IDLE, all outputs 0 and `valid_stall_o`=0.

Source files
------------

// File: rtl/pipeline_mem.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_mem : RV32IM memory stage - data RAM, RV32M mul/div, WB registers
// Revision 1.0
// ---------------------------------------------------------------------------
module pipeline_mem #(
  parameter int DMEM_AW = 7
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] alu_out_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] mul_in1_i,
  input  logic [4:0]  rd_i,
  input  logic [5:0]  main_opcode_i,
  input  logic        main_stall_i,
  output logic        valid_stall_o,
  output logic [31:0] wb_data_o,
  output logic [4:0]  rd_o,
  output logic        we_o,
  output logic [31:0] reg_forwarding_mem_o
);

  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LW  = 6'b100010;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SW  = 6'b101010;
  localparam logic [5:0] OP_TRAP = 6'b001111;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_DIV  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [31:0]        r_mem [0:(1<<DMEM_AW)-1];
  logic [1:0]         r_state;
  logic [5:0]         r_cnt;
  logic [31:0]        r_quo;
  logic [31:0]        r_rem;
  logic [31:0]        r_dvsr;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_is_rem;

  logic [DMEM_AW-1:0] w_idx;
  logic               w_is_load;
  logic               w_is_store;
  logic               w_is_mul;
  logic               w_is_div;
  logic               w_div_start;
  logic               w_store_en;
  logic [3:0]         w_strb;
  logic [31:0]        w_wlane;
  logic [31:0]        w_word;
  logic [31:0]        w_shifted;
  logic [15:0]        w_half;
  logic [7:0]         w_byte;
  logic signed [32:0] w_ma;
  logic signed [32:0] w_mb;
  logic signed [65:0] w_prod;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [31:0]        w_abs_a;
  logic [31:0]        w_abs_b;
  logic               w_div_zero;
  logic               w_div_ovf;
  logic [32:0]        w_shift;
  logic [32:0]        w_diff;
  logic               w_ge;
  logic [31:0]        w_div_res;
  logic [31:0]        w_result;
  logic               w_we;
  logic               w_unused_bits;

  assign w_idx      = alu_out_i[DMEM_AW+1:2];
  assign w_is_load  = (main_opcode_i == OP_LB)  || (main_opcode_i == OP_LH) ||
                      (main_opcode_i == OP_LW)  || (main_opcode_i == OP_LBU) ||
                      (main_opcode_i == OP_LHU);
  assign w_is_store = (main_opcode_i == OP_SB) || (main_opcode_i == OP_SH) ||
                      (main_opcode_i == OP_SW);
  assign w_is_mul   = (main_opcode_i[5:2] == 4'b0100);
  assign w_is_div   = (main_opcode_i[5:2] == 4'b0101);

  assign w_div_start   = (r_state == ST_IDLE) && w_is_div && !main_stall_i;
  assign valid_stall_o = w_div_start || (r_state == ST_DIV);

  // Byte-strobed store path; data replicated across lanes so strobes select
  assign w_store_en = w_is_store && !main_stall_i && !valid_stall_o;
  always_comb begin
    w_strb  = 4'b1111;
    w_wlane = wdata_i;
    if (main_opcode_i == OP_SB) begin
      w_strb  = 4'b0001 << alu_out_i[1:0];
      w_wlane = {4{wdata_i[7:0]}};
    end else if (main_opcode_i == OP_SH) begin
      w_strb  = alu_out_i[1] ? 4'b1100 : 4'b0011;
      w_wlane = {2{wdata_i[15:0]}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) r_mem[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
      end
    end
  end

  assign w_word    = r_mem[w_idx];
  assign w_shifted = w_word >> {alu_out_i[1:0], 3'b000};
  assign w_byte    = w_shifted[7:0];
  assign w_half    = alu_out_i[1] ? w_word[31:16] : w_word[15:0];

  // rs1 is signed except MULHU; rs2 signed only for MUL/MULH
  assign w_ma   = {(main_opcode_i[1:0] != 2'b11) & mul_in1_i[31], mul_in1_i};
  assign w_mb   = {!main_opcode_i[1] & wdata_i[31], wdata_i};
  assign w_prod = w_ma * w_mb;

  assign w_signed   = !main_opcode_i[0];
  assign w_a_neg    = w_signed && mul_in1_i[31];
  assign w_b_neg    = w_signed && wdata_i[31];
  assign w_abs_a    = w_a_neg ? -mul_in1_i : mul_in1_i;
  assign w_abs_b    = w_b_neg ? -wdata_i : wdata_i;
  assign w_div_zero = (wdata_i == 32'd0);
  assign w_div_ovf  = w_signed && (mul_in1_i == 32'h8000_0000) && (wdata_i == 32'hFFFF_FFFF);

  // Restoring step: partial remainder stays below the divisor, so 33 bits suffice
  assign w_shift   = {r_rem, r_quo[31]};
  assign w_diff    = w_shift - {1'b0, r_dvsr};
  assign w_ge      = !w_diff[32];
  assign w_div_res = r_is_rem ? (r_neg_r ? -r_rem : r_rem)
                              : (r_neg_q ? -r_quo : r_quo);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state  <= ST_IDLE;
      r_cnt    <= 6'd0;
      r_quo    <= 32'd0;
      r_rem    <= 32'd0;
      r_dvsr   <= 32'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_is_rem <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_div_start) begin
            r_is_rem <= main_opcode_i[1];
            if (w_div_zero) begin
              r_quo   <= 32'hFFFF_FFFF;
              r_rem   <= mul_in1_i;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= ST_DONE;
            end else if (w_div_ovf) begin
              r_quo   <= 32'h8000_0000;
              r_rem   <= 32'd0;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= ST_DONE;
            end else begin
              r_quo   <= w_abs_a;
              r_rem   <= 32'd0;
              r_dvsr  <= w_abs_b;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_cnt   <= 6'd0;
              r_state <= ST_DIV;
            end
          end
        end
        ST_DIV: begin
          r_quo <= {r_quo[30:0], w_ge};
          r_rem <= w_ge ? w_diff[31:0] : w_shift[31:0];
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) r_state <= ST_DONE;
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_result = alu_out_i;
    if (r_state == ST_DONE) begin
      w_result = w_div_res;
    end else if (w_is_mul) begin
      w_result = (main_opcode_i[1:0] == 2'b00) ? w_prod[31:0] : w_prod[63:32];
    end else begin
      case (main_opcode_i)
        OP_LB:   w_result = {{24{w_byte[7]}}, w_byte};
        OP_LH:   w_result = {{16{w_half[15]}}, w_half};
        OP_LW:   w_result = w_word;
        OP_LBU:  w_result = {24'd0, w_byte};
        OP_LHU:  w_result = {16'd0, w_half};
        default: w_result = alu_out_i;
      endcase
    end
  end

  assign w_we = (w_is_load || (main_opcode_i[5:4] == 2'b00) ||
                 (main_opcode_i[5:3] == 3'b010) || (main_opcode_i[5:3] == 3'b111)) &&
                (main_opcode_i != OP_TRAP) && (rd_i != 5'd0) && !main_stall_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wb_data_o <= 32'd0;
      rd_o      <= 5'd0;
      we_o      <= 1'b0;
    end else if (!valid_stall_o) begin
      wb_data_o <= w_result;
      rd_o      <= rd_i;
      we_o      <= w_we;
    end else begin
      we_o      <= 1'b0;
    end
  end

  assign reg_forwarding_mem_o = wb_data_o;

  assign w_unused_bits = ^{alu_out_i[31:DMEM_AW+2], w_shifted[31:8], w_prod[65:64]};

endmodule
`default_nettype wire
